if_inst_queue: RTL and testbench

- Instruction queue between ifu and the ID stage. Consumes the per-fetch tuple ifu emits: PC, instruction word, trap bus and prediction tag.
- Decouples IF stalls (icache/MMU latency) from ID stalls.
- Flushed on redirect.
- Blocks further intake after a trapping fetch, so no wrong-path instructions follow a page fault.

---
 rtl/if_inst_queue_pkg.sv | 8 +
 rtl/if_inst_queue.sv | 120 ++++++++++++
 tb/tb_if_inst_queue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_inst_queue_pkg.sv
// Shared constants for the IF->ID instruction queue: NOP encoding and trap bus layout.
package if_inst_queue_pkg;

  localparam int unsigned TrapLen           = 8;
  localparam int unsigned TrapInstPageFault = 1;
  localparam logic [31:0] InstNop           = 32'h0000_0013;

endpackage

// File: rtl/if_inst_queue.sv
// Circular instruction queue between fetch and decode; stops intake after a trapping fetch.
// Optional zero-latency pass-through when empty: define IF_INST_QUEUE_BYPASS_EN.
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TRAP_W = TrapLen
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_pc_i,
  input  logic [31:0]              in_inst_i,
  input  logic [TRAP_W-1:0]        in_trap_i,
  input  logic                     in_pdt_res_i,
  input  logic [31:0]              in_pdt_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_inst_o,
  output logic [TRAP_W-1:0]        out_trap_o,
  output logic                     out_pdt_res_o,
  output logic [31:0]              out_pdt_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 97 + TRAP_W;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          trap_hold_q, trap_hold_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          full, empty, bypass, enq, deq, accept;
  logic [EW-1:0] in_entry, head;

  assign in_entry = {in_pdt_pc_i, in_pdt_res_i, in_trap_i, in_inst_i, in_pc_i};
  assign head     = mem_q[rd_ptr_q];

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign in_ready_o = !full && !trap_hold_q && !flush_i && !rst;
  assign accept     = in_valid_i && in_ready_o;

`ifdef IF_INST_QUEUE_BYPASS_EN
  assign bypass = empty && accept && out_ready_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction is consumed directly, so it is never written.
  assign enq         = accept && !bypass;
  assign deq         = !empty && !flush_i && out_ready_i;
  assign out_valid_o = (!empty && !flush_i) || bypass;
  assign count_o     = count_q;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    trap_hold_d = trap_hold_q;
    if (flush_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      trap_hold_d = 1'b0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (!enq && deq) count_d = count_q - CW'(1);
      if (accept && |in_trap_i) trap_hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trap_hold_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      trap_hold_q <= trap_hold_d;
    end
  end

  // Data array is deliberately not reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= in_entry;
  end

  always_comb begin
    out_pc_o      = '0;
    out_inst_o    = InstNop;
    out_trap_o    = '0;
    out_pdt_res_o = 1'b0;
    out_pdt_pc_o  = '0;
    if (bypass) begin
      out_pc_o      = in_pc_i;
      out_inst_o    = in_inst_i;
      out_trap_o    = in_trap_i;
      out_pdt_res_o = in_pdt_res_i;
      out_pdt_pc_o  = in_pdt_pc_i;
    end else if (!empty) begin
      out_pc_o      = head[31:0];
      out_inst_o    = head[63:32];
      out_trap_o    = head[64 +: TRAP_W];
      out_pdt_res_o = head[64 + TRAP_W];
      out_pdt_pc_o  = head[EW-1 -: 32];
    end
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed self-checking bench for if_inst_queue (DEPTH = 4).
module tb_if_inst_queue;
  import if_inst_queue_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TRAP_W = TrapLen;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       in_pc_i;
  logic [31:0]       in_inst_i;
  logic [TRAP_W-1:0] in_trap_i;
  logic              in_pdt_res_i;
  logic [31:0]       in_pdt_pc_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_pc_o;
  logic [31:0]       out_inst_o;
  logic [TRAP_W-1:0] out_trap_o;
  logic              out_pdt_res_o;
  logic [31:0]       out_pdt_pc_o;
  logic [2:0]        count_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mq[$];
  logic [TRAP_W-1:0] pf_bit;

  always #5 clk = ~clk;

  if_inst_queue #(.DEPTH(DEPTH), .TRAP_W(TRAP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_pc_i       (in_pc_i),
    .in_inst_i     (in_inst_i),
    .in_trap_i     (in_trap_i),
    .in_pdt_res_i  (in_pdt_res_i),
    .in_pdt_pc_i   (in_pdt_pc_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_inst_o    (out_inst_o),
    .out_trap_o    (out_trap_o),
    .out_pdt_res_o (out_pdt_res_o),
    .out_pdt_pc_o  (out_pdt_pc_o),
    .count_o       (count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Checks against the scoreboard, then advances one clock and updates it.
  task automatic tick_chk(input string tag);
    bit exp_rdy, enq, deq;
    #1;
    exp_rdy = (mq.size() < DEPTH);
    chk({tag, ".ready"}, 64'(in_ready_o), 64'(exp_rdy));
    chk({tag, ".valid"}, 64'(out_valid_o), 64'(mq.size() != 0));
    chk({tag, ".count"}, 64'(count_o), 64'(mq.size()));
    if (mq.size() != 0) chk({tag, ".pc"}, 64'(out_pc_o), 64'(mq[0]));
    else chk({tag, ".nop"}, 64'(out_inst_o), 64'h13);
    enq = in_valid_i && exp_rdy;
    deq = out_ready_i && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back(in_pc_i);
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [TRAP_W-1:0] trap);
    in_valid_i   = v;
    in_pc_i      = pc;
    in_inst_i    = pc ^ 32'h0000_0013;
    in_trap_i    = trap;
    in_pdt_res_i = pc[2];
    in_pdt_pc_i  = pc + 32'h100;
  endtask

  initial begin
    pf_bit = '0;
    pf_bit[TrapInstPageFault] = 1'b1;
    rst = 1'b1;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    set_in(1'b0, 32'h0, '0);
    #12;
    chk("rst.ready", 64'(in_ready_o), 64'd0);
    chk("rst.valid", 64'(out_valid_o), 64'd0);
    chk("rst.count", 64'(count_o), 64'd0);
    chk("rst.nop", 64'(out_inst_o), 64'h13);
    edge1();
    rst = 1'b0;
    edge1();
    chk("rel.ready", 64'(in_ready_o), 64'd1);

    // Fill with out_ready low, then drain in order.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h8000_0000 + 32'(4 * i), '0);
      tick_chk("fill");
    end
    #1;
    chk("full.count", 64'(count_o), 64'd4);
    chk("full.ready", 64'(in_ready_o), 64'd0);
    chk("full.inst", 64'(out_inst_o), 64'h8000_0013);
    chk("full.pdtpc", 64'(out_pdt_pc_o), 64'h8000_0100);
    set_in(1'b0, 32'h0, '0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick_chk("drain");

    // Six more with out_ready toggling; pointers wrap.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 32'h8000_0010 + 32'(4 * i), '0);
      out_ready_i = i[0];
      tick_chk("wrap");
    end
    set_in(1'b0, 32'h0, '0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick_chk("wdrain");

    // Simultaneous enqueue/dequeue at count 2 and at full.
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h8000_0100, '0); tick_chk("sim.f0");
    set_in(1'b1, 32'h8000_0104, '0); tick_chk("sim.f1");
    out_ready_i = 1'b1;
    set_in(1'b1, 32'h8000_0108, '0); tick_chk("sim.c2");
    chk("sim.c2.count", 64'(count_o), 64'd2);
    chk("sim.c2.head", 64'(out_pc_o), 64'h8000_0104);
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h8000_010C, '0); tick_chk("sim.f2");
    set_in(1'b1, 32'h8000_0110, '0); tick_chk("sim.f3");
    out_ready_i = 1'b1;
    set_in(1'b1, 32'h8000_0114, '0); tick_chk("sim.full");
    chk("sim.full.count", 64'(count_o), 64'd3);
    chk("sim.full.head", 64'(out_pc_o), 64'h8000_0108);

    // Flush with 3 queued, handshakes presented in the same cycle.
    flush_i = 1'b1;
    set_in(1'b1, 32'h9000_0000, '0);
    #1;
    chk("fl.valid", 64'(out_valid_o), 64'd0);
    chk("fl.ready", 64'(in_ready_o), 64'd0);
    edge1();
    flush_i = 1'b0;
    set_in(1'b0, 32'h0, '0);
    #1;
    chk("fl.count", 64'(count_o), 64'd0);
    chk("fl.after.valid", 64'(out_valid_o), 64'd0);
    chk("fl.nop", 64'(out_inst_o), 64'h13);
    mq.delete();

    // Trapping fetch blocks further intake but still drains.
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h8000_1000, pf_bit);
    edge1();
    set_in(1'b1, 32'h8000_1004, '0);
    #1;
    chk("trap.ready", 64'(in_ready_o), 64'd0);
    edge1();
    chk("trap.count", 64'(count_o), 64'd1);
    set_in(1'b0, 32'h0, '0);
    out_ready_i = 1'b1;
    #1;
    chk("trap.pc", 64'(out_pc_o), 64'h8000_1000);
    chk("trap.bus", 64'(out_trap_o), 64'(pf_bit));
    edge1();
    chk("trap.drained", 64'(count_o), 64'd0);
    chk("trap.hold", 64'(in_ready_o), 64'd0);
    flush_i = 1'b1;
    edge1();
    flush_i = 1'b0;
    #1;
    chk("trap.cleared", 64'(in_ready_o), 64'd1);

    // Empty queue with both handshakes high.
    in_valid_i = 1'b1;
    in_pc_i = 32'h8000_2000;
    in_inst_i = 32'h0050_0093;
    in_trap_i = '0;
    out_ready_i = 1'b1;
    #1;
`ifdef IF_INST_QUEUE_BYPASS_EN
    chk("byp.valid", 64'(out_valid_o), 64'd1);
    chk("byp.inst", 64'(out_inst_o), 64'h0050_0093);
    chk("byp.count", 64'(count_o), 64'd0);
    edge1();
    in_valid_i = 1'b0;
    #1;
    chk("byp.after", 64'(count_o), 64'd0);
`else
    chk("lat.valid0", 64'(out_valid_o), 64'd0);
    edge1();
    in_valid_i = 1'b0;
    #1;
    chk("lat.valid1", 64'(out_valid_o), 64'd1);
    chk("lat.inst", 64'(out_inst_o), 64'h0050_0093);
    chk("lat.count", 64'(count_o), 64'd1);
    edge1();
    chk("lat.drained", 64'(count_o), 64'd0);
`endif

    // Reset asserted mid-stream with two entries queued.
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h8000_3000, '0); edge1();
    set_in(1'b1, 32'h8000_3004, '0); edge1();
    set_in(1'b0, 32'h0, '0);
    chk("mid.count", 64'(count_o), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid.valid", 64'(out_valid_o), 64'd0);
    chk("mid.zero", 64'(count_o), 64'd0);
    chk("mid.nop", 64'(out_inst_o), 64'h13);
    chk("mid.pc", 64'(out_pc_o), 64'd0);
    chk("mid.ready", 64'(in_ready_o), 64'd0);
    edge1();
    rst = 1'b0;
    edge1();
    chk("mid.rel.ready", 64'(in_ready_o), 64'd1);
    chk("mid.rel.count", 64'(count_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
